// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - shared types and constants for the block-bus memory responder
//
// Purpose: responder FSM state encoding, request op encoding and the default
// geometry/latency used by bus_mem_responder and bus_mem_array.
// Ports: none (package).
package bus_mem_pkg;

  localparam int BUS_ADDR_W      = 5;
  localparam int BUS_DATA_W      = 16;
  localparam int BUS_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/bus_mem_array.sv
// rtl/bus_mem_array.sv - flop-based block storage with one registered read and one write port
//
// Purpose: 2**ADDR_W blocks of DATA_W bits. Reset loads every block with its
// byte-index pattern: byte lane k of block a = (a*DATA_W/8 + k) mod 256.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   rd_en_i, rd_addr_i   - load rd_data_o with the addressed block on this edge
//   rd_data_o            - registered read data, holds between reads, 0 after reset
//   wr_en_i, wr_addr_i,
//   wr_data_i            - write the addressed block on this edge
module bus_mem_array
  import bus_mem_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      // The 8-bit cast performs the mod-256 wrap of the byte index.
      for (int a = 0; a < DEPTH; a++) begin
        for (int k = 0; k < NBYTES; k++) begin
          mem_q[a][8*k +: 8] <= 8'(a * NBYTES + k);
        end
      end
    end else begin
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - main-memory responder for the cache block bus
//
// Purpose: accepts one block read (fetch) or write (write-back) at a time and
// completes it LATENCY cycles after the request is first seen, with a
// one-cycle bus_done pulse. Optional macro BUS_MEM_STATS_EN adds saturating
// completed-read/write counters.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   bus_rd, bus_wr       - fetch / write-back request, held until bus_done
//   bus_addr             - block address
//   bus_wdata            - write-back data
//   bus_rdata            - fetched data, valid in the bus_done cycle of a read
//   bus_done             - one-cycle completion pulse
//   rd_count, wr_count   - (BUS_MEM_STATS_EN only) completed reads / writes
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int LATENCY = BUS_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_done
`ifdef BUS_MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;

  logic              req;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;

  assign req = bus_rd | bus_wr;

  // The read port loads on the edge entering DONE. With LATENCY==1 that edge
  // is the IDLE acceptance edge, so the live bus inputs are used directly.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = addr_q;
    if (state_q == IDLE && LATENCY == 1) begin
      rd_en   = bus_rd & ~bus_wr;
      rd_addr = bus_addr;
    end else if (state_q == WAIT && cnt_q == 4'd1) begin
      rd_en = (op_q == OP_RD);
    end
  end

  // Writes commit on the edge leaving DONE.
  assign wr_en = (state_q == DONE) && (op_q == OP_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= bus_addr;
            wdata_q <= bus_wdata;
            op_q    <= bus_wr ? OP_WR : OP_RD;
            if (LATENCY == 1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  bus_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(bus_rdata),
    .wr_en_i  (wr_en),
    .wr_addr_i(addr_q),
    .wr_data_i(wdata_q)
  );

  assign bus_done = done_q;

`ifdef BUS_MEM_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == DONE) begin
      if (op_q == OP_WR) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - self-checking bench for bus_mem_responder (LATENCY 4 and 1 instances)
`timescale 1ns/1ps
module tb_bus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [1:0]       rd_s = '0;
  logic [1:0]       wr_s = '0;
  logic [1:0][4:0]  addr_s = '0;
  logic [1:0][15:0] wdata_s = '0;
  logic [15:0]      rdata0, rdata1;
  logic             done0, done1;
`ifdef BUS_MEM_STATS_EN
  logic [15:0]      rdc0, wrc0, rdc1, wrc1;
`endif

  bus_mem_responder #(.ADDR_W(5), .DATA_W(16), .LATENCY(4)) dut0 (
    .clk(clk), .reset(reset),
    .bus_rd(rd_s[0]), .bus_wr(wr_s[0]), .bus_addr(addr_s[0]), .bus_wdata(wdata_s[0]),
    .bus_rdata(rdata0), .bus_done(done0)
`ifdef BUS_MEM_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0)
`endif
  );

  bus_mem_responder #(.ADDR_W(5), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .bus_rd(rd_s[1]), .bus_wr(wr_s[1]), .bus_addr(addr_s[1]), .bus_wdata(wdata_s[1]),
    .bus_rdata(rdata1), .bus_done(done1)
`ifdef BUS_MEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic logic done_of(input int i);
    return (i == 1) ? done1 : done0;
  endfunction

  function automatic logic [15:0] rdata_of(input int i);
    return (i == 1) ? rdata1 : rdata0;
  endfunction

  // Behavioural model: a transaction accepted in cycle c (only while idle)
  // completes in cycle c+L; reads return the memory contents at that point,
  // writes land when the done cycle ends.
  int unsigned cyc = 0;
  bit          started = 0;
  logic [15:0] m_mem [2][32];
  bit          m_busy [2];
  int unsigned m_done_at [2];
  bit          m_wr [2];
  logic [4:0]  m_addr [2];
  logic [15:0] m_wdata [2];
  bit          e_done [2];
  logic [15:0] e_rdata [2];
  int          e_rdc [2];
  int          e_wrc [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int a = 0; a < 32; a++) m_mem[i][a] = 16'((2*a + 1) * 256 + 2*a);
        m_busy[i]  = 0;
        e_done[i]  = 0;
        e_rdata[i] = 16'h0;
        e_rdc[i]   = 0;
        e_wrc[i]   = 0;
      end else begin
        if (!m_busy[i] && (rd_s[i] || wr_s[i])) begin
          m_busy[i]    = 1;
          m_done_at[i] = cyc + lat_of(i);
          m_wr[i]      = wr_s[i];
          m_addr[i]    = addr_s[i];
          m_wdata[i]   = wdata_s[i];
        end
        if (m_busy[i] && m_done_at[i] == cyc) begin
          if (m_wr[i]) begin
            m_mem[i][m_addr[i]] = m_wdata[i];
            if (e_wrc[i] < 65535) e_wrc[i]++;
          end else begin
            if (e_rdc[i] < 65535) e_rdc[i]++;
          end
          m_busy[i] = 0;
        end
        e_done[i] = m_busy[i] && (m_done_at[i] == cyc + 1);
        if (e_done[i] && !m_wr[i]) e_rdata[i] = m_mem[i][m_addr[i]];
      end
    end
    if (reset) started = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("bus_done", i, 32'(done_of(i)), 32'(e_done[i]));
        chk("bus_rdata", i, 32'(rdata_of(i)), 32'(e_rdata[i]));
`ifdef BUS_MEM_STATS_EN
        chk("rd_count", i, 32'(i ? rdc1 : rdc0), 32'(e_rdc[i]));
        chk("wr_count", i, 32'(i ? wrc1 : wrc0), 32'(e_wrc[i]));
`endif
      end
    end
  end

  // Issue one request on DUT i right after a rising edge and wait for its
  // done; lat is the number of cycles from first visibility to done.
  task automatic req(input int i, input bit rd, input bit wr, input logic [4:0] a,
                     input logic [15:0] d, input bit drop_early,
                     output int lat, output logic [15:0] rdat);
    @(posedge clk);
    #1;
    rd_s = '0;
    wr_s = '0;
    rd_s[i] = rd;
    wr_s[i] = wr;
    addr_s[i] = a;
    wdata_s[i] = d;
    lat = -1;
    rdat = 16'hxxxx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (drop_early && n == 1) begin
        rd_s[i] = 1'b0;
        wr_s[i] = 1'b0;
      end
      if (done_of(i)) begin
        lat = n;
        rdat = rdata_of(i);
        break;
      end
    end
    if (lat < 0) chk("done_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      rd_s = '0;
      wr_s = '0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_s = '0;
    wr_s = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_bad++;
    summary();
    $fatal(1);
  end

  initial begin
    int lat;
    int dones;
    logic [15:0] rd;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rdata", 0, 32'(rdata0), 32'h0);
    chk("reset_done", 0, 32'(done0), 32'h0);

    // Fetch block 5 after reset.
    req(0, 1, 0, 5'd5, 16'h0, 0, lat, rd);
    chk("t1_latency", 0, 32'(lat), 32'd4);
    chk("t1_rdata", 0, 32'(rd), 32'h0B0A);
    idle(1);
    @(negedge clk);
    chk("t1_done_after", 0, 32'(done0), 32'h0);

    // Write then read back; neighbour untouched.
    req(0, 0, 1, 5'd5, 16'hBEEF, 0, lat, rd);
    chk("t2_wr_latency", 0, 32'(lat), 32'd4);
    req(0, 1, 0, 5'd5, 16'h0, 0, lat, rd);
    chk("t2_rd_latency", 0, 32'(lat), 32'd4);
    chk("t2_rdata", 0, 32'(rd), 32'hBEEF);
    req(0, 1, 0, 5'd4, 16'h0, 0, lat, rd);
    chk("t2_block4", 0, 32'(rd), 32'h0908);
    idle(1);

    // Write-back immediately followed by fetch.
    req(0, 0, 1, 5'h13, 16'h1234, 0, lat, rd);
    req(0, 1, 0, 5'h0A, 16'h0, 0, lat, rd);
    chk("t3_latency", 0, 32'(lat), 32'd4);
    chk("t3_rdata", 0, 32'(rd), 32'h1514);
    req(0, 1, 0, 5'h13, 16'h0, 0, lat, rd);
    chk("t3_wb_data", 0, 32'(rd), 32'h1234);
    idle(2);

    // LATENCY=1 instance, back-to-back.
    req(1, 1, 0, 5'd31, 16'h0, 0, lat, rd);
    chk("t4_latency", 1, 32'(lat), 32'd1);
    chk("t4_rdata", 1, 32'(rd), 32'h3F3E);
    req(1, 1, 0, 5'd0, 16'h0, 0, lat, rd);
    chk("t4_b2b_a0", 1, 32'(rd), 32'h0100);
    req(1, 1, 0, 5'd16, 16'h0, 0, lat, rd);
    chk("t4_b2b_a16", 1, 32'(rd), 32'h2120);
    req(1, 1, 0, 5'd3, 16'h0, 0, lat, rd);
    chk("t4_b2b_lat", 1, 32'(lat), 32'd1);
    chk("t4_b2b_a3", 1, 32'(rd), 32'h0706);
    idle(2);

    // Reset in the second WAIT cycle of a write.
    @(posedge clk);
    #1;
    wr_s[0] = 1'b1;
    addr_s[0] = 5'd2;
    wdata_s[0] = 16'hAAAA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr_s = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) dones++;
    end
    chk("t5_no_done", 0, 32'(dones), 32'd0);
    chk("t5_rdata", 0, 32'(rdata0), 32'h0);
    req(0, 1, 0, 5'd2, 16'h0, 0, lat, rd);
    chk("t5_unwritten", 0, 32'(rd), 32'h0504);
    idle(1);

    // Simultaneous rd and wr is a write.
    pulse_reset();
    req(0, 1, 1, 5'd7, 16'h5555, 0, lat, rd);
    chk("t6_latency", 0, 32'(lat), 32'd4);
    chk("t6_rdata_held", 0, 32'(rd), 32'h0);
    idle(1);
`ifdef BUS_MEM_STATS_EN
    chk("t6_wr_count", 0, 32'(wrc0), 32'd1);
    chk("t6_rd_count", 0, 32'(rdc0), 32'd0);
`endif
    req(0, 1, 0, 5'd7, 16'h0, 0, lat, rd);
    chk("t6_rdata", 0, 32'(rd), 32'h5555);
    idle(1);

    // Randomized traffic on both instances, checked by the model every cycle.
    for (int t = 0; t < 400; t++) begin
      int i;
      int op;
      i  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      req(i, op != 2, op >= 2, 5'($urandom), 16'($urandom),
          $urandom_range(0, 3) == 0, lat, rd);
      chk("rand_latency", i, 32'(lat), 32'(lat_of(i)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);

    summary();
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
Main-memory responder for the cache-to-memory block bus. It accepts a single-block read (fetch) or write (write-back) request on bus_rd/bus_wr/bus_addr. Each request completes after a fixed number of wait cycles with a one-cycle bus_done pulse. It backs 32 blocks of 16 bits each (2 bytes per block) and sits on the memory side of the cache controller, serving as both the system memory model and the responder FSM.

Parameters:
ADDR_W, 5, block address width; depth = 2**ADDR_W blocks
DATA_W, 16, block width in bits; must be a multiple of 8
LATENCY, 4, cycles from the first cycle a request is visible to the bus_done cycle; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
bus_rd  input  1  fetch request from the cache; held until bus_done is sampled
bus_wr  input  1  write-back request from the cache; held until bus_done is sampled
bus_addr  input  ADDR_W  block address
bus_wdata  input  DATA_W  write-back block data (cache bus_dout)
bus_rdata  output  DATA_W  fetched block data (cache bus_din)
bus_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE, bus_done=0, bus_rdata=0, counter=0.
  - Every block is initialised to the byte pattern: byte lane k of block a = (a*DATA_W/8 + k) mod 256. With defaults, block a = {2a+1, 2a}, e.g. block 5 = 16'h0B0A.
  - Reset has priority over all activity, including mid-transaction; no done is issued and no write is committed.
- States:
  - IDLE: if bus_wr|bus_rd, latch addr, wdata and op (write wins if both are high; the read is dropped). Go to DONE if LATENCY==1, else WAIT with cnt=LATENCY-1.
  - WAIT: decrement cnt; go to DONE when cnt reaches 1. Inputs are ignored; latched values are used.
  - DONE: bus_done=1 for exactly this cycle. Return to IDLE.
- Timing: request first visible in cycle t → bus_done high in cycle t+LATENCY exactly.
- Read: bus_rdata is registered. It is loaded with mem[latched addr] on the edge entering DONE, is valid during the DONE cycle, and holds until the next read enters DONE. Writes do not change it.
- Write: mem[latched addr] <= latched wdata on the edge leaving DONE.
- A read of the same address issued right after a write returns the new data.
- Back-to-back requests: the requester may switch from bus_wr to bus_rd in the cycle after DONE. IDLE accepts it immediately; the minimum turnaround is 1 idle cycle.
- Requests present during WAIT/DONE are not re-sampled. A request still high in the DONE cycle is the requester's own and is ignored; only IDLE samples.
- A request dropped before done still completes (commit plus pulse).
- bus_done is never asserted in IDLE or WAIT; two pulses are never adjacent.
- bus_addr is not range-checked; it is exactly ADDR_W bits, so it wraps naturally.

Optional Feature:
- BUS_MEM_STATS_EN defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on the edge leaving DONE for its op.
  - Both saturate at 16'hFFFF and clear on reset.
  - A simultaneous rd&wr request counts as a write only.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bus_mem_pkg:
  - state enum {IDLE, WAIT, DONE}
  - constants BUS_ADDR_W=5, BUS_DATA_W=16, BUS_MEM_LATENCY=4
  - op encoding (OP_RD, OP_WR)
- Sub-module bus_mem_array: flop storage with synchronous reset-to-pattern, one registered read port and one write port. The responder FSM and wait counter stay in the top module.

Test Plan:
1. Reset, then hold bus_rd with addr 5 from cycle t → bus_done only in cycle t+4; bus_rdata=16'h0B0A; bus_done=0 at t+5.
2. Write addr 5 with 16'hBEEF, then read addr 5 → done pulses 4 cycles after each request; read returns 16'hBEEF. Block 4 still reads 16'h0908.
3. Cache-style WB→fetch: bus_wr addr 0x13 data 16'h1234 until done, then bus_rd addr 0x0A starting the next cycle → second done 4 cycles later; bus_rdata=16'h1514; no spurious pulse; mem[0x13]=16'h1234.
4. LATENCY=1 instance: bus_rd addr 31 in cycle t → done at t+1 with 16'h3F3E. Back-to-back requests give alternating done/idle cycles.
5. Write addr 2 data 16'hAAAA; assert reset in the second WAIT cycle → no bus_done; bus_rdata=0; a subsequent read of addr 2 returns 16'h0504.
6. bus_rd and bus_wr both high, addr 7, data 16'h5555 → treated as a write. bus_rdata is unchanged; a later read returns 16'h5555. With BUS_MEM_STATS_EN defined: wr_count=1, rd_count=0.
